// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status coming in, stage enable/bubble controls going out.
// The master drives the pipeline status, and the slave (the controller) drives the stage controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_br_taken;
  logic             mem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic             ex_mem_en;
  logic             mem_wb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_br_taken, mem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
           mem_wb_bubble, mem_err, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_br_taken, mem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
           mem_wb_bubble, mem_err, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: dmem freeze > branch flush > load-use stall.
// Outputs are combinational from state + inputs; a branch flush interrupted by a freeze resumes afterwards.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_t;

  localparam int FW = 3;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  state_t           r_state, w_state_next;
  logic [FW-1:0]    r_flush_left, w_flush_left_next;
  logic [WW-1:0]    r_wait_cnt, w_wait_cnt_next;
  logic             r_mem_err, w_mem_err_next;
  logic [CNT_W-1:0] r_stall_count;

  logic w_hazard, w_frozen, w_flush_mode;
  logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_bubble, w_ex_mem_en, w_mem_wb_bubble;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_hazard = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  assign w_frozen     = (r_state == MEM_WAIT) ? !hz.dmem_ready : (hz.mem_req && !hz.dmem_ready);
  assign w_flush_mode = (r_state == FLUSH) || ((r_state == MEM_WAIT) && (r_flush_left != '0));

  always_comb begin
    w_state_next      = r_state;
    w_flush_left_next = r_flush_left;
    w_wait_cnt_next   = r_wait_cnt;
    w_mem_err_next    = r_mem_err;
    w_pc_en           = 1'b1;
    w_if_id_en        = 1'b1;
    w_if_id_flush     = 1'b0;
    w_id_ex_en        = 1'b1;
    w_id_ex_bubble    = 1'b0;
    w_ex_mem_en       = 1'b1;
    w_mem_wb_bubble   = 1'b0;
    if (rst) begin
      w_pc_en         = 1'b0;
      w_if_id_en      = 1'b0;
      w_id_ex_en      = 1'b0;
      w_ex_mem_en     = 1'b0;
      w_if_id_flush   = 1'b1;
      w_id_ex_bubble  = 1'b1;
      w_mem_wb_bubble = 1'b1;
    end else if (w_frozen) begin
      w_pc_en         = 1'b0;
      w_if_id_en      = 1'b0;
      w_id_ex_en      = 1'b0;
      w_ex_mem_en     = 1'b0;
      w_mem_wb_bubble = 1'b1;
      if (r_state == MEM_WAIT) begin
        if (r_wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
          w_mem_err_next  = 1'b1;
          w_wait_cnt_next = '0;
          w_state_next    = (r_flush_left != '0) ? FLUSH : RUN;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end else begin
        w_wait_cnt_next = WW'(1);
        w_state_next    = MEM_WAIT;
        // The branch stays parked in EX during the freeze; remember the full flush it owes.
        if ((r_state == RUN) && hz.ex_br_taken)
          w_flush_left_next = FW'(FLUSH_CYCLES);
      end
    end else if (w_flush_mode) begin
      w_if_id_flush     = 1'b1;
      w_id_ex_bubble    = 1'b1;
      w_flush_left_next = r_flush_left - 1'b1;
      w_wait_cnt_next   = '0;
      w_state_next      = (r_flush_left > FW'(1)) ? FLUSH : RUN;
    end else if (hz.ex_br_taken) begin
      w_if_id_flush     = 1'b1;
      w_id_ex_bubble    = 1'b1;
      w_flush_left_next = FW'(FLUSH_CYCLES - 1);
      w_wait_cnt_next   = '0;
      w_state_next      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (w_hazard) begin
      w_pc_en         = 1'b0;
      w_if_id_en      = 1'b0;
      w_id_ex_bubble  = 1'b1;
      w_wait_cnt_next = '0;
      w_state_next    = RUN;
    end else begin
      w_wait_cnt_next = '0;
      w_state_next    = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_flush_left  <= '0;
      r_wait_cnt    <= '0;
      r_mem_err     <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_flush_left <= w_flush_left_next;
      r_wait_cnt   <= w_wait_cnt_next;
      r_mem_err    <= w_mem_err_next;
      if (!w_pc_en && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign hz.pc_en         = w_pc_en;
  assign hz.if_id_en      = w_if_id_en;
  assign hz.if_id_flush   = w_if_id_flush;
  assign hz.id_ex_en      = w_id_ex_en;
  assign hz.id_ex_bubble  = w_id_ex_bubble;
  assign hz.ex_mem_en     = w_ex_mem_en;
  assign hz.mem_wb_bubble = w_mem_wb_bubble;
  assign hz.mem_err       = r_mem_err;
  assign hz.stall_count   = r_stall_count;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: the stimulus side predicts each cycle's controls from the hazard rules;
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipeline_hazard_ctrl;
  localparam int FC = 2;
  localparam int MT = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  typedef struct packed {
    logic          pc_en;
    logic          if_id_en;
    logic          if_id_flush;
    logic          id_ex_en;
    logic          id_ex_bubble;
    logic          ex_mem_en;
    logic          mem_wb_bubble;
    logic          mem_err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  int    txn    = 0;

  // Reference model state: remaining flush cycles owed, whether dmem is being waited on,
  // how many stall cycles the current wait has lasted, sticky error, and stall tally.
  int m_flush_rem = 0;
  bit m_waiting   = 0;
  int m_wait_cyc  = 0;
  bit m_err       = 0;
  int m_cnt       = 0;

  task automatic step(input bit r, input int rs1, input int rs2, input bit u1, input bit u2,
                      input bit mr, input int rd, input bit br, input bit mreq, input bit rdy,
                      input string nm);
    exp_t e;
    bit   frozen, hazard;
    @(posedge clk);
    #1;
    rst            = r;
    hz.id_rs1      = rs1[4:0];
    hz.id_rs2      = rs2[4:0];
    hz.id_use_rs1  = u1;
    hz.id_use_rs2  = u2;
    hz.ex_memread  = mr;
    hz.ex_rd       = rd[4:0];
    hz.ex_br_taken = br;
    hz.mem_req     = mreq;
    hz.dmem_ready  = rdy;
    if (r) begin
      m_flush_rem = 0; m_waiting = 0; m_wait_cyc = 0; m_err = 0; m_cnt = 0;
      e = '{pc_en:0, if_id_en:0, if_id_flush:1, id_ex_en:0, id_ex_bubble:1,
            ex_mem_en:0, mem_wb_bubble:1, mem_err:0, cnt:'0};
    end else begin
      e = '{pc_en:1, if_id_en:1, if_id_flush:0, id_ex_en:1, id_ex_bubble:0,
            ex_mem_en:1, mem_wb_bubble:0, mem_err:m_err, cnt:CW'(m_cnt)};
      hazard = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      frozen = m_waiting ? !rdy : (mreq && !rdy);
      if (frozen) begin
        e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_en = 0; e.mem_wb_bubble = 1;
        if (!m_waiting) begin
          if (m_flush_rem == 0 && br) m_flush_rem = FC;
          m_waiting  = 1;
          m_wait_cyc = 1;
        end else begin
          m_wait_cyc++;
          if (m_wait_cyc == MT) begin
            m_err     = 1;
            m_waiting = 0;
          end
        end
      end else begin
        m_waiting = 0;
        if (m_flush_rem > 0) begin
          e.if_id_flush = 1; e.id_ex_bubble = 1;
          m_flush_rem--;
        end else if (br) begin
          e.if_id_flush = 1; e.id_ex_bubble = 1;
          m_flush_rem = FC - 1;
        end else if (hazard) begin
          e.pc_en = 0; e.if_id_en = 0; e.id_ex_bubble = 1;
        end
      end
      if (!e.pc_en && m_cnt < CMAX) m_cnt++;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, nm);
  endtask

  always @(negedge clk) begin
    exp_t  a, e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{pc_en:hz.pc_en, if_id_en:hz.if_id_en, if_id_flush:hz.if_id_flush,
             id_ex_en:hz.id_ex_en, id_ex_bubble:hz.id_ex_bubble, ex_mem_en:hz.ex_mem_en,
             mem_wb_bubble:hz.mem_wb_bubble, mem_err:hz.mem_err, cnt:hz.stall_count};
      checks++;
      txn++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s txn=%0d actual pc/ifid/flush/idex/bub/exmem/wbbub/err=%b%b%b%b%b%b%b%b cnt=%0d required=%b%b%b%b%b%b%b%b cnt=%0d",
                 nm, txn, a.pc_en, a.if_id_en, a.if_id_flush, a.id_ex_en, a.id_ex_bubble,
                 a.ex_mem_en, a.mem_wb_bubble, a.mem_err, a.cnt, e.pc_en, e.if_id_en,
                 e.if_id_flush, e.id_ex_en, e.id_ex_bubble, e.ex_mem_en, e.mem_wb_bubble,
                 e.mem_err, e.cnt);
      end else begin
        $display("txn %0d %s ok pc_en=%b flush=%b bubble=%b err=%b cnt=%0d",
                 txn, nm, a.pc_en, a.if_id_flush, a.id_ex_bubble, a.mem_err, a.cnt);
      end
    end
  end

  initial begin
    int rp;
    hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
    hz.ex_memread = 0; hz.ex_rd = 0; hz.ex_br_taken = 0; hz.mem_req = 0; hz.dmem_ready = 1;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset");
    idle("run_idle");

    step(0, 5, 7, 1, 1, 1, 5, 0, 0, 1, "load_use_rs1");
    step(0, 5, 7, 1, 1, 0, 0, 0, 0, 1, "load_use_clear");

    step(0, 0, 3, 1, 1, 1, 0, 0, 0, 1, "load_x0_nostall");
    step(0, 1, 6, 1, 0, 1, 6, 0, 0, 1, "rs2_unused_nostall");
    step(0, 1, 6, 0, 1, 1, 6, 0, 0, 1, "load_use_rs2");
    idle("run_idle");

    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "branch_flush1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "branch_flush2_shadow");
    idle("after_branch_run");

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mem_freeze");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "mem_release");
    idle("after_mem_run");

    for (int i = 0; i < 2; i++) step(0, 4, 0, 1, 0, 1, 4, 1, 1, 0, "combo_freeze");
    step(0, 4, 0, 1, 0, 1, 4, 1, 1, 1, "combo_release_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "combo_flush2");
    idle("combo_run");

    for (int i = 0; i < MT + 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "timeout_wait");
    idle("err_sticky");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "wait_before_rst");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "rst_mid_wait");
    idle("after_rst_run");

    rp = 8;
    for (int i = 0; i < 400; i++) begin
      if (i % 32 == 0) rp = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 3 : 8);
      step(($urandom_range(0, 99) == 0),
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) < rp), "random");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
